ldm_stm_sequencer: RTL and testbench

Multi-cycle sequencer for block-transfer instructions (LDM/STM). It walks a 16-bit register list, one register per cycle in ascending index order. For each register it drives the register-file read port (store) or write port (load) and the data-memory address and write strobe. An optional base-register writeback cycle follows the transfers. It sits between the decoder/control unit, the register file and data memory. Its `Busy` output stalls fetch/decode while a transfer is in progress.

---
 rtl/ldm_stm_sequencer_pkg.sv | 22 ++
 rtl/ldm_stm_sequencer_reg_list_encoder.sv | 22 ++
 rtl/ldm_stm_sequencer.sv | 160 ++++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package ldm_stm_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Addressing mode is taken from {P,U}.
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } amode_e;

  localparam int unsigned WORD_BYTES_DEF = 4;
  localparam logic [3:0]  PC_IDX         = 4'd15;

endpackage

// File: rtl/ldm_stm_sequencer_reg_list_encoder.sv
// Combinational register-list encoder: lowest set index, any-set flag and popcount.
module reg_list_encoder (
  input  logic [15:0] mask_i,
  output logic [3:0]  idx_o,
  output logic        valid_o,
  output logic [4:0]  count_o
);

  always_comb begin
    idx_o   = 4'd0;
    count_o = 5'd0;
    // Scan downwards so the lowest set bit is the final assignment.
    for (int i = 15; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o = 4'(i);
      end
      count_o = count_o + 5'(mask_i[i]);
    end
    valid_o = |mask_i;
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks the register list one register per cycle, then an
// optional base writeback cycle, then a one-cycle Done pulse.
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int unsigned WORD_BYTES = WORD_BYTES_DEF
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Load,
  input  logic        P,
  input  logic        U,
  input  logic        W,
  input  logic [3:0]  Rn,
  input  logic [31:0] RnVal,
  input  logic [15:0] RegList,
  input  logic [31:0] ReadData,
  input  logic [31:0] RegData,
  output logic        Busy,
  output logic        Done,
  output logic [3:0]  RegAddr,
  output logic        RegWE,
  output logic [31:0] RegWD,
  output logic        PCWE,
  output logic [31:0] MemAddr,
  output logic        MemWE,
  output logic [31:0] MemWD
);

  state_e      state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic [31:0] ptr_q, ptr_d;
  logic        load_q, load_d;
  logic        wb_en_q, wb_en_d;
  logic [3:0]  rn_q, rn_d;
  logic [31:0] wb_val_q, wb_val_d;

  logic [15:0] enc_mask;
  logic [3:0]  enc_idx;
  logic        enc_valid;
  logic [4:0]  enc_count;
  logic [31:0] step;
  logic [31:0] span;
  logic [31:0] start_addr;

  // One encoder serves both Start (popcount of the new list) and XFER (next register).
  assign enc_mask = (state_q == ST_IDLE) ? RegList : mask_q;

  reg_list_encoder u_enc (
    .mask_i  (enc_mask),
    .idx_o   (enc_idx),
    .valid_o (enc_valid),
    .count_o (enc_count)
  );

  assign step = 32'(WORD_BYTES);
  assign span = step * {27'd0, enc_count};

  always_comb begin
    start_addr = RnVal;
    case (amode_e'({P, U}))
      MODE_IA: start_addr = RnVal;
      MODE_IB: start_addr = RnVal + step;
      MODE_DA: start_addr = RnVal - span + step;
      MODE_DB: start_addr = RnVal - span;
      default: start_addr = RnVal;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    ptr_d    = ptr_q;
    load_d   = load_q;
    wb_en_d  = wb_en_q;
    rn_d     = rn_q;
    wb_val_d = wb_val_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          mask_d   = RegList;
          ptr_d    = start_addr;
          load_d   = Load;
          rn_d     = Rn;
          wb_val_d = U ? (RnVal + span) : (RnVal - span);
          // A loaded base register keeps its loaded value.
          wb_en_d  = W & ~(Load & RegList[Rn]);
          state_d  = enc_valid ? ST_XFER : ST_DONE;
        end
      end
      ST_XFER: begin
        mask_d = mask_q & (mask_q - 16'd1);
        ptr_d  = ptr_q + step;
        if (enc_count > 5'd1) begin
          state_d = ST_XFER;
        end else begin
          state_d = wb_en_q ? ST_WB : ST_DONE;
        end
      end
      ST_WB:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy    = (state_q != ST_IDLE);
    Done    = (state_q == ST_DONE);
    RegAddr = 4'd0;
    RegWE   = 1'b0;
    RegWD   = 32'd0;
    PCWE    = 1'b0;
    MemAddr = 32'd0;
    MemWE   = 1'b0;
    MemWD   = 32'd0;
    case (state_q)
      ST_XFER: begin
        RegAddr = enc_idx;
        MemAddr = ptr_q;
        if (load_q) begin
          RegWD = ReadData;
          if (enc_idx == PC_IDX) PCWE = 1'b1;
          else                   RegWE = 1'b1;
        end else begin
          MemWE = 1'b1;
          MemWD = RegData;
        end
      end
      ST_WB: begin
        RegAddr = rn_q;
        RegWD   = wb_val_q;
        if (rn_q == PC_IDX) PCWE = 1'b1;
        else                RegWE = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      mask_q   <= 16'd0;
      ptr_q    <= 32'd0;
      load_q   <= 1'b0;
      wb_en_q  <= 1'b0;
      rn_q     <= 4'd0;
      wb_val_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      ptr_q    <= ptr_d;
      load_q   <= load_d;
      wb_en_q  <= wb_en_d;
      rn_q     <= rn_d;
      wb_val_q <= wb_val_d;
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: expected strobe events are queued at
// Start and matched against strobes observed on the falling clock edge.
module tb_ldm_stm_sequencer;

  localparam logic [3:0] K_MEM  = 4'd1;
  localparam logic [3:0] K_REG  = 4'd2;
  localparam logic [3:0] K_PC   = 4'd3;
  localparam logic [3:0] K_DONE = 4'd4;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Load = 1'b0;
  logic        P = 1'b0;
  logic        U = 1'b0;
  logic        W = 1'b0;
  logic [3:0]  Rn = 4'd0;
  logic [31:0] RnVal = 32'd0;
  logic [15:0] RegList = 16'd0;
  logic [31:0] ReadData;
  logic [31:0] RegData;
  logic        Busy;
  logic        Done;
  logic [3:0]  RegAddr;
  logic        RegWE;
  logic [31:0] RegWD;
  logic        PCWE;
  logic [31:0] MemAddr;
  logic        MemWE;
  logic [31:0] MemWD;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          busy_cnt = 0;
  logic [67:0] sb[$];

  ldm_stm_sequencer #(.WORD_BYTES(4)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Load(Load), .P(P), .U(U), .W(W),
    .Rn(Rn), .RnVal(RnVal), .RegList(RegList), .ReadData(ReadData), .RegData(RegData),
    .Busy(Busy), .Done(Done), .RegAddr(RegAddr), .RegWE(RegWE), .RegWD(RegWD),
    .PCWE(PCWE), .MemAddr(MemAddr), .MemWE(MemWE), .MemWD(MemWD)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] reg_model(input logic [3:0] i);
    return {16'hC0DE, 8'h00, i, i};
  endfunction

  function automatic logic [67:0] mk(input logic [3:0] k, input logic [31:0] a, input logic [31:0] d);
    return {k, a, d};
  endfunction

  assign ReadData = rd_model(MemAddr);
  assign RegData  = reg_model(RegAddr);

  task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic match(input string tag, input logic [67:0] ev);
    if (sb.size() == 0) chk({tag, "_unexpected"}, ev, '0);
    else                chk(tag, ev, sb.pop_front());
  endtask

  // Monitor: every strobe or Done is one observed transaction.
  initial begin
    forever begin
      @(negedge CLK);
      if (Busy) busy_cnt++;
      if (MemWE) match("memw", mk(K_MEM, MemAddr, MemWD));
      if (RegWE) match("regw", mk(K_REG, {28'd0, RegAddr}, RegWD));
      if (PCWE)  match("pcw",  mk(K_PC,  {28'd0, RegAddr}, RegWD));
      if (Done)  match("done", mk(K_DONE, 32'(busy_cnt), 32'(cyc - start_cyc)));
    end
  end

  task automatic expect_op(input logic ld, input logic p, input logic u, input logic w,
                           input logic [3:0] rn, input logic [31:0] base,
                           input logic [15:0] list, input bit with_done);
    int          n = 0;
    logic [31:0] addr;
    logic [31:0] wbv;
    bit          wb;
    for (int i = 0; i < 16; i++) if (list[i]) n++;
    case ({p, u})
      2'b01:   addr = base;
      2'b11:   addr = base + 32'd4;
      2'b00:   addr = base - 32'(4 * n) + 32'd4;
      default: addr = base - 32'(4 * n);
    endcase
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        if (!ld)         sb.push_back(mk(K_MEM, addr, reg_model(4'(i))));
        else if (i == 15) sb.push_back(mk(K_PC, 32'd15, rd_model(addr)));
        else             sb.push_back(mk(K_REG, 32'(i), rd_model(addr)));
        addr = addr + 32'd4;
      end
    end
    wb  = w && (n != 0) && !(ld && list[rn]);
    wbv = u ? base + 32'(4 * n) : base - 32'(4 * n);
    if (wb) sb.push_back(mk((rn == 4'd15) ? K_PC : K_REG, {28'd0, rn}, wbv));
    if (with_done) sb.push_back(mk(K_DONE, 32'(n + 1 + (wb ? 1 : 0)), 32'(n + 1 + (wb ? 1 : 0))));
  endtask

  task automatic drive(input logic ld, input logic p, input logic u, input logic w,
                       input logic [3:0] rn, input logic [31:0] base, input logic [15:0] list);
    @(negedge CLK); #1;
    Load = ld; P = p; U = u; W = w; Rn = rn; RnVal = base; RegList = list;
    Start = 1'b1;
    start_cyc = cyc;
    busy_cnt = 0;
  endtask

  // hold > 0 keeps Start high for that many further edges with scrambled operands.
  task automatic run_op(input string tag, input logic ld, input logic p, input logic u,
                        input logic w, input logic [3:0] rn, input logic [31:0] base,
                        input logic [15:0] list, input int hold);
    int k = 0;
    expect_op(ld, p, u, w, rn, base, list, 1'b1);
    drive(ld, p, u, w, rn, base, list);
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK); #1;
      RegList = ~list; Load = ~ld; RnVal = base ^ 32'hFFFF_0000; W = ~w;
    end
    @(negedge CLK); #1;
    Start = 1'b0;
    while (Busy && k < 40) begin
      @(negedge CLK); #1;
      k++;
    end
    if (k >= 40) chk({tag, "_timeout"}, 68'(Busy), '0);
    chk({tag, "_drain"}, 68'(sb.size()), '0);
    $display("op %s: list=%h ld=%0d pu=%0d%0d w=%0d rn=%0d base=%h busy_cycles=%0d",
             tag, list, ld, p, u, w, rn, base, busy_cnt);
  endtask

  initial begin
    #1;
    chk("rst_busy",    68'(Busy),    '0);
    chk("rst_done",    68'(Done),    '0);
    chk("rst_regwe",   68'(RegWE),   '0);
    chk("rst_pcwe",    68'(PCWE),    '0);
    chk("rst_memwe",   68'(MemWE),   '0);
    chk("rst_regaddr", 68'(RegAddr), '0);
    chk("rst_memaddr", 68'(MemAddr), '0);
    chk("rst_regwd",   68'(RegWD),   '0);
    chk("rst_memwd",   68'(MemWD),   '0);
    repeat (3) @(negedge CLK);
    #1 Reset = 1'b0;

    run_op("stm_ia_wb",   1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h0000_0100, 16'h000B, 0);
    run_op("ldm_db_pc",   1'b1, 1'b1, 1'b0, 1'b0, 4'd4,  32'h0000_0200, 16'h8006, 0);
    run_op("ldm_rn_in",   1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  32'h0000_0400, 16'h0004, 0);
    run_op("empty",       1'b0, 1'b0, 1'b1, 1'b1, 4'd5,  32'h0000_0600, 16'h0000, 0);
    run_op("start_ign",   1'b0, 1'b0, 1'b1, 1'b0, 4'd6,  32'h0000_0300, 16'h0007, 4);
    run_op("stm_ib_pcwb", 1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 32'h0000_0080, 16'h00C1, 0);
    run_op("ldm_da_wb",   1'b1, 1'b0, 1'b0, 1'b1, 4'd3,  32'h0000_0700, 16'h0101, 0);
    run_op("stm_db_wrap", 1'b0, 1'b1, 1'b0, 1'b1, 4'd9,  32'h0000_0004, 16'h0030, 0);

    // Reset during the second XFER of a 4-register LDM: only R4 may be written.
    sb.push_back(mk(K_REG, 32'd4, rd_model(32'h0000_0500)));
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 32'h0000_0500, 16'h00F0);
    @(negedge CLK); #1;
    Start = 1'b0;
    @(posedge CLK); #2;
    Reset = 1'b1;
    #1;
    chk("midrst_regwe", 68'(RegWE),     '0);
    chk("midrst_pcwe",  68'(PCWE),      '0);
    chk("midrst_memwe", 68'(MemWE),     '0);
    chk("midrst_busy",  68'(Busy),      '0);
    chk("midrst_first", 68'(sb.size()), '0);
    $display("op midrst: list=00f0 reset in 2nd XFER");
    repeat (2) @(negedge CLK);
    #1 Reset = 1'b0;

    run_op("post_rst",    1'b1, 1'b0, 1'b1, 1'b1, 4'd1,  32'h0000_0500, 16'h00F0, 0);

    for (int r = 0; r < 8; r++) begin
      logic [15:0] list;
      list = 16'($urandom);
      if ($urandom_range(0, 4) == 0) list = 16'd0;
      run_op("rand", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             4'($urandom), $urandom & 32'hFFFF_FFFC, list, 0);
    end

    repeat (2) @(negedge CLK);
    chk("sb_final", 68'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
